// File: rtl/change_dispenser.sv
// Coin-by-coin change payout: greedy largest-available-coin selection with a
// four-phase req/ack handshake to the hopper and a bounded wait for each ack.
module change_dispenser #(
    parameter int W           = 8,
    parameter int COIN_L      = 25,
    parameter int COIN_M      = 10,
    parameter int COIN_S      = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] amount,
    input  logic         empty_l,
    input  logic         empty_m,
    input  logic         empty_s,
    input  logic         coin_ack,
    output logic         coin_req,
    output logic [1:0]   coin_sel,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] remainder
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [W-1:0]  VAL_L    = W'(COIN_L);
    localparam logic [W-1:0]  VAL_M    = W'(COIN_M);
    localparam logic [W-1:0]  VAL_S    = W'(COIN_S);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_t        state, state_n;
    logic [W-1:0]  rem, rem_n;
    logic [1:0]    sel, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  sel_val;

    always_comb begin
        case (sel)
            2'd2:    sel_val = VAL_L;
            2'd1:    sel_val = VAL_M;
            default: sel_val = VAL_S;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            rem   <= '0;
            sel   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        sel_n   = sel;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    rem_n   = amount;
                    state_n = S_SELECT;
                end
            end
            S_SELECT: begin
                // Hopper empty flags matter only here; a coin already requested
                // is not withdrawn if its hopper reports empty later.
                if (rem == '0) begin
                    state_n = S_DONE;
                end else if (!empty_l && (VAL_L <= rem)) begin
                    sel_n   = 2'd2;
                    cnt_n   = '0;
                    state_n = S_REQ;
                end else if (!empty_m && (VAL_M <= rem)) begin
                    sel_n   = 2'd1;
                    cnt_n   = '0;
                    state_n = S_REQ;
                end else if (!empty_s && (VAL_S <= rem)) begin
                    sel_n   = 2'd0;
                    cnt_n   = '0;
                    state_n = S_REQ;
                end else begin
                    state_n = S_ERROR;
                end
            end
            S_REQ: begin
                if (coin_ack) begin
                    rem_n   = rem - sel_val;
                    state_n = S_RELEASE;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_ERROR;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                if (!coin_ack) begin
                    state_n = S_SELECT;
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERROR: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign coin_req  = (state == S_REQ);
    assign coin_sel  = sel;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERROR);
    assign remainder = rem;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed payouts against a denomination-count model; a monitor
// pops expected coin/done/err events whenever the dispenser presents one.
module tb_change_dispenser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] amount;
    logic         empty_l, empty_m, empty_s;
    logic         coin_ack;
    logic         coin_req;
    logic [1:0]   coin_sel;
    logic         busy, done, err;
    logic [W-1:0] remainder;

    change_dispenser #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount),
        .empty_l(empty_l), .empty_m(empty_m), .empty_s(empty_s),
        .coin_ack(coin_ack), .coin_req(coin_req), .coin_sel(coin_sel),
        .busy(busy), .done(done), .err(err), .remainder(remainder)
    );

    always #5 clk = ~clk;

    // Event word: {kind, coin, remainder}; kind 1 = coin request, 2 = done, 3 = err
    logic [11:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int hop_en = 1;
    int ack_limit = 1000000;
    int acks_given = 0;
    int req_cycles = 0;
    int req_rises = 0;

    task automatic check_val(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_event(input string name, input logic [11:0] got);
        logic [11:0] want;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected event %h, nothing expected", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", name, got, want);
            end
        end
    endtask

    // Reference model: pay each denomination as many times as it fits, largest first.
    function automatic void model(input int amt, input bit el, input bit em,
                                  input bit es, input bit noack);
        int r;
        int val[3];
        bit avail[3];
        r = amt;
        val[0] = 5;   val[1] = 10;  val[2] = 25;
        avail[0] = !es; avail[1] = !em; avail[2] = !el;
        if (noack) begin
            for (int c = 2; c >= 0; c--) begin
                if (avail[c] && val[c] <= r && r != 0) begin
                    exp_q.push_back({2'd1, 2'(c), 8'(r)});
                    exp_q.push_back({2'd3, 2'd0, 8'(r)});
                    return;
                end
            end
        end else begin
            for (int c = 2; c >= 0; c--) begin
                if (avail[c]) begin
                    int n;
                    n = r / val[c];
                    for (int k = 0; k < n; k++) begin
                        exp_q.push_back({2'd1, 2'(c), 8'(r)});
                        r = r - val[c];
                    end
                end
            end
        end
        if (r == 0) exp_q.push_back({2'd2, 2'd0, 8'd0});
        else        exp_q.push_back({2'd3, 2'd0, 8'(r)});
    endfunction

    // Hopper: acks a request after 0..3 cycles, drops ack 0..3 cycles after req falls
    initial begin
        int dly;
        dly = 0;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || hop_en == 0) begin
                coin_ack = 1'b0;
                dly = 0;
            end else if (coin_req && !coin_ack) begin
                if (acks_given < ack_limit) begin
                    if (dly == 0) begin
                        coin_ack = 1'b1;
                        acks_given++;
                        dly = $urandom_range(0, 3);
                    end else begin
                        dly--;
                    end
                end
            end else if (!coin_req && coin_ack) begin
                if (dly == 0) begin
                    coin_ack = 1'b0;
                    dly = $urandom_range(0, 3);
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (coin_req) req_cycles++;
                if (coin_req && !prev_req) begin
                    req_rises++;
                    check_event("coin", {2'd1, coin_sel, remainder});
                end
                if (done) check_event("done", {2'd2, 2'd0, remainder});
                if (err)  check_event("err",  {2'd3, 2'd0, remainder});
                prev_req = coin_req;
            end
        end
    end

    task automatic pay(input int amt, input bit el, input bit em, input bit es,
                       input bit glitch, output int lat, output bit is_err);
        int cyc;
        bit ended;
        @(negedge clk);
        empty_l = el; empty_m = em; empty_s = es;
        amount = W'(amt);
        start = 1'b1;
        model(amt, el, em, es, hop_en == 0);
        req_cycles = 0;
        cyc = 0;
        ended = 0;
        is_err = 0;
        while (!ended && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            amount = W'($urandom_range(0, 255));
            if (glitch && cyc == 3) begin
                start = 1'b1;
                amount = 8'd50;
            end
            cyc++;
            if (done || err) begin
                ended = 1;
                is_err = err;
            end
        end
        if (!ended) check_val("payout_finish", 0, 1);
        lat = cyc;
    endtask

    initial begin
        int lat;
        bit is_err;
        int base;
        rst = 1'b1;
        start = 1'b0;
        amount = '0;
        empty_l = 0; empty_m = 0; empty_s = 0;
        #12;
        check_val("rst_coin_req", int'(coin_req), 0);
        check_val("rst_coin_sel", int'(coin_sel), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_err", int'(err), 0);
        check_val("rst_remainder", int'(remainder), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // 40 with a start/amount=50 glitch while busy: L, M, S then done
        pay(40, 0, 0, 0, 1, lat, is_err);
        check_val("pay40_err", int'(is_err), 0);
        pay(30, 1, 0, 0, 0, lat, is_err);
        check_val("pay30_err", int'(is_err), 0);
        pay(7, 0, 0, 0, 0, lat, is_err);
        check_val("pay7_err", int'(is_err), 1);

        hop_en = 0;
        pay(25, 0, 0, 0, 0, lat, is_err);
        check_val("timeout_req_cycles", req_cycles, 15);
        @(negedge clk);
        check_val("timeout_req_low", int'(coin_req), 0);
        check_val("timeout_remainder", int'(remainder), 25);
        hop_en = 1;

        pay(0, 0, 0, 0, 0, lat, is_err);
        check_val("zero_latency", lat, 2);
        check_val("zero_no_req", req_cycles, 0);

        // Reset while the second coin of 35 is being requested
        acks_given = 0;
        ack_limit = 1;
        base = req_rises;
        @(negedge clk);
        amount = 8'd35;
        start = 1'b1;
        model(35, 0, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && req_rises < base + 2; i++) @(negedge clk);
        check_val("rst_test_reached_req2", int'(req_rises >= base + 2), 1);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_coin_req", int'(coin_req), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_remainder", int'(remainder), 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        ack_limit = 1000000;
        pay(10, 0, 0, 0, 0, lat, is_err);
        check_val("after_rst_pay10", int'(is_err), 0);

        for (int t = 0; t < 30; t++) begin
            pay($urandom_range(0, 160), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 1), lat, is_err);
        end

        @(negedge clk);
        check_val("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out change coin-by-coin to a coin hopper after a sale.
- The vending controller pulses start with the change owed. The block greedily selects the largest available coin and runs a four-phase req/ack handshake with the hopper for each coin.
- It signals done when the full amount is paid, or err when it cannot pay exactly or the hopper stops responding.

Parameters:
- W, 8, width of amount and remainder.
- COIN_L, 25, value of large coin (coin_sel = 2).
- COIN_M, 10, value of medium coin (coin_sel = 1).
- COIN_S, 5, value of small coin (coin_sel = 0).
- ACK_TIMEOUT, 15, max cycles in REQ without coin_ack before error.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request to pay amount; sampled only in IDLE.
- amount  input  W  change owed; latched on accepted start.
- empty_l  input  1  large-coin hopper empty.
- empty_m  input  1  medium-coin hopper empty.
- empty_s  input  1  small-coin hopper empty.
- coin_ack  input  1  hopper has ejected the requested coin (four-phase).
- coin_req  output  1  request one coin of type coin_sel.
- coin_sel  output  2  coin type: 2 = L, 1 = M, 0 = S.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, full amount paid.
- err  output  1  one-cycle pulse, payout aborted.
- remainder  output  W  amount still unpaid (register rem).

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state = IDLE, rem = 0, coin_sel = 0, timeout counter = 0. All outputs are 0.
- Reset mid-payout drops coin_req immediately and discards rem. No resume.
- States: IDLE, SELECT, REQ, RELEASE, DONE, ERROR. All outputs are Moore, decoded from registered state and registers.
- IDLE:
  - start = 1: rem <= amount, then go to SELECT.
  - start = 0: stay in IDLE.
- SELECT (1 cycle):
  - rem == 0: go to DONE.
  - Otherwise pick the first coin in order L, M, S whose value <= rem and whose empty flag is 0. Register the pick into coin_sel, clear the timeout counter, go to REQ.
  - No such coin: go to ERROR.
  - Empty flags are sampled here only, not during REQ.
- REQ:
  - coin_req = 1; coin_sel is held stable.
  - coin_ack = 1: rem <= rem - value(coin_sel), go to RELEASE.
  - coin_ack = 0: counter increments. When counter reaches ACK_TIMEOUT-1 with no ack, go to ERROR. Entry to ERROR therefore happens ACK_TIMEOUT cycles after entering REQ.
- RELEASE:
  - coin_req = 0.
  - Wait for coin_ack = 0, then go to SELECT. No timeout here.
- DONE: done = 1 for one cycle, then go to IDLE.
- ERROR: err = 1 for one cycle, then go to IDLE. rem (remainder) holds the unpaid amount until the next accepted start.
- Arithmetic:
  - Subtraction never underflows, because a coin is selected only when value <= rem.
  - Amounts that are not a multiple of COIN_S end in ERROR with remainder = amount mod COIN_S, after all coins that can be paid have been paid.
- start while busy is ignored. amount changing while busy has no effect.
- amount = 0: IDLE -> SELECT -> DONE. No coin_req.
- Per-coin minimum cost: SELECT + REQ + RELEASE = 3 cycles with an immediate ack.
- busy = 1 in SELECT, REQ, RELEASE, DONE and ERROR.

Test Plan:
- amount = 40, all hoppers full, ack one cycle after each req and released one cycle later -> coin_sel sequence 2, 1, 0; done pulses once; remainder = 0; err never set.
- amount = 30, empty_l = 1 -> coin_sel sequence 1, 1, 1; done; remainder = 0.
- amount = 7 -> one coin with coin_sel = 0; then err pulse; remainder = 2; done never set.
- amount = 25, coin_ack held 0 -> coin_req high for exactly 15 cycles, then err; remainder = 25; coin_req = 0 afterward.
- rst asserted in REQ of the second coin of amount = 35 -> coin_req, busy and remainder go to 0 asynchronously. A later start with amount = 10 pays one M coin normally.
- amount = 0 -> done exactly 2 cycles after start, no coin_req. A start pulse during busy with amount = 50 is ignored, and remainder is unaffected.
